// File: rtl/aes_sbox_pipe.sv
// Two-stage pipelined AES byte substitution, forward or inverse per transaction.
// S1 registers the raw input and mode; S2 registers the substituted result.
// Valid/ready handshake with full backpressure and one transaction per clock.
module aes_sbox_pipe #(
    parameter int unsigned LANES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_inv,
    input  logic [LANES*8-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_inv,
    output logic [LANES*8-1:0]   out_data,
    output logic                 busy
);

    localparam int unsigned W = LANES * 8;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 = x^2 * x^4 * ... * x^128; 0 maps to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int unsigned k = 1; k < 8; k++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    // Forward affine: x ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
    function automatic logic [7:0] affine_fwd(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    // Inverse affine: rotl1 ^ rotl3 ^ rotl6 ^ 0x05.
    function automatic logic [7:0] affine_inv(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    endfunction

    function automatic logic [7:0] sub_byte(input logic [7:0] x, input logic inv);
        return inv ? gf_inv(affine_inv(x)) : affine_fwd(gf_inv(x));
    endfunction

    function automatic logic [W-1:0] sub_word(input logic [W-1:0] d, input logic inv);
        logic [W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            r[8*i +: 8] = sub_byte(d[8*i +: 8], inv);
        end
        return r;
    endfunction

    logic          s1_valid_q, s1_valid_d;
    logic          s1_inv_q,   s1_inv_d;
    logic [W-1:0]  s1_data_q,  s1_data_d;
    logic          s2_valid_q, s2_valid_d;
    logic          s2_inv_q,   s2_inv_d;
    logic [W-1:0]  s2_data_q,  s2_data_d;
    logic          s2_adv;
    logic          accept;

    assign s2_adv    = s1_valid_q & (~s2_valid_q | out_ready);
    assign in_ready  = ~s1_valid_q | s2_adv;
    assign accept    = in_valid & in_ready;
    assign out_valid = s2_valid_q;
    assign out_inv   = s2_inv_q;
    assign out_data  = s2_data_q;
    assign busy      = s1_valid_q | s2_valid_q;

    // Next-state for both stages: a refill wins over a drain in the same cycle.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_inv_d   = s1_inv_q;
        s1_data_d  = s1_data_q;
        s2_valid_d = s2_valid_q;
        s2_inv_d   = s2_inv_q;
        s2_data_d  = s2_data_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_inv_d   = in_inv;
            s1_data_d  = in_data;
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s2_adv) begin
            s2_valid_d = 1'b1;
            s2_inv_d   = s1_inv_q;
            s2_data_d  = sub_word(s1_data_q, s1_inv_q);
        end else if (s2_valid_q & out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    // Pipeline registers; reset clears valids and data and overrides any handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_inv_q   <= 1'b0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_inv_q   <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_inv_q   <= s1_inv_d;
            s1_data_q  <= s1_data_d;
            s2_valid_q <= s2_valid_d;
            s2_inv_q   <= s2_inv_d;
            s2_data_q  <= s2_data_d;
        end
    end

endmodule

// File: tb/tb_aes_sbox_pipe.sv
// Scoreboard bench for aes_sbox_pipe: expected results are queued when an
// input is accepted and compared in order when an output is taken.
module tb_aes_sbox_pipe;

    localparam int unsigned LANES = 4;
    localparam int unsigned W     = LANES * 8;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic          in_inv;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_inv;
    logic [W-1:0]  out_data;
    logic          busy;

    aes_sbox_pipe #(.LANES(LANES)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inv    (in_inv),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inv   (out_inv),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [128:0] got, input logic [128:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference S-box tables built by walking the multiplicative group with
    // generator 3 (p) and its inverse (q); the inverse box is the table inverse.
    logic [7:0] fwd_t [256];
    logic [7:0] inv_t [256];

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int unsigned k);
        return (v << k) | (v >> (8 - k));
    endfunction

    task automatic build_tables();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            fwd_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        fwd_t[0] = 8'h63;
        for (int i = 0; i < 256; i++) inv_t[fwd_t[i]] = 8'(i);
    endtask

    function automatic logic [W-1:0] model_word(input logic [W-1:0] d, input logic m);
        logic [W-1:0] r;
        for (int i = 0; i < int'(LANES); i++)
            r[8*i +: 8] = m ? inv_t[d[8*i +: 8]] : fwd_t[d[8*i +: 8]];
        return r;
    endfunction

    // Scoreboard and output monitor, sampled on the falling edge.
    logic [W:0]    sb [$];
    int unsigned   pop_cyc [$];
    int unsigned   cyc = 0;
    logic          stall_prev = 1'b0;
    logic [W:0]    held;
    logic [W:0]    exp_e;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) check("hold_stable", 129'({out_inv, out_data}), 129'(held));
            if (in_valid && in_ready) sb.push_back({in_inv, model_word(in_data, in_inv)});
            if (out_valid && out_ready) begin
                check("sb_nonempty", 129'(sb.size() != 0), 129'(1));
                if (sb.size() != 0) begin
                    exp_e = sb.pop_front();
                    check("out_word", 129'({out_inv, out_data}), 129'(exp_e));
                    pop_cyc.push_back(cyc);
                end
            end
            stall_prev = out_valid && !out_ready;
            held = {out_inv, out_data};
        end
    end

    task automatic send(input logic [W-1:0] d, input logic m, output int unsigned tries);
        logic acc;
        in_valid = 1'b1;
        in_data  = d;
        in_inv   = m;
        tries    = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            tries++;
        end while (!acc && tries < 100);
        check("accept", 129'(acc), 129'(1));
    endtask

    task automatic drain();
        int unsigned t;
        in_valid = 1'b0;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain_empty", 129'(sb.size()), 129'(0));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] r;
        for (int i = 0; i < int'(LANES); i++) r[8*i +: 8] = 8'($urandom);
        return r;
    endfunction

    logic [7:0]   pat_in  [4] = '{8'h01, 8'hff, 8'h53, 8'h00};
    logic [7:0]   pat_out [4] = '{8'h7c, 8'h16, 8'hed, 8'h63};
    logic [W-1:0] w_in, w_out, w;
    logic         sweep_done;
    int unsigned  tr, n0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        build_tables();
        for (int i = 0; i < int'(LANES); i++) begin
            w_in[8*i +: 8]  = pat_in[i % 4];
            w_out[8*i +: 8] = pat_out[i % 4];
        end

        // Reset with traffic active.
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_inv    = 1'b1;
        in_data   = rand_word();
        out_ready = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("rst_out_valid", 129'(out_valid), 129'(0));
        check("rst_out_data",  129'(out_data),  129'(0));
        check("rst_out_inv",   129'(out_inv),   129'(0));
        check("rst_busy",      129'(busy),      129'(0));
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 129'(in_ready), 129'(1));
        @(posedge clk);
        #1;

        // Directed forward vector with latency check.
        send(w_in, 1'b0, tr);
        in_valid = 1'b0;
        @(negedge clk);
        check("fwd_lat_early", 129'(out_valid), 129'(0));
        @(negedge clk);
        check("fwd_lat_valid", 129'(out_valid), 129'(1));
        check("fwd_data",      129'(out_data),  129'(w_out));
        check("fwd_inv",       129'(out_inv),   129'(0));
        drain();

        // Directed inverse vector.
        send(w_out, 1'b1, tr);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("inv_valid", 129'(out_valid), 129'(1));
        check("inv_data",  129'(out_data),  129'(w_in));
        check("inv_inv",   129'(out_inv),   129'(1));
        drain();

        // Full byte sweep in every lane, both modes, under random backpressure.
        sweep_done = 1'b0;
        fork
            begin
                for (int m = 0; m < 2; m++)
                    for (int v = 0; v < 256; v++) begin
                        for (int i = 0; i < int'(LANES); i++) w[8*i +: 8] = 8'(v + i);
                        send(w, m[0], tr);
                    end
                in_valid   = 1'b0;
                sweep_done = 1'b1;
            end
            begin
                while (!sweep_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Back-to-back stream with alternating modes, no backpressure.
        n0 = pop_cyc.size();
        for (int k = 0; k < 16; k++) begin
            send(rand_word(), k[0], tr);
            check("stream_nostall", 129'(tr), 129'(1));
        end
        drain();
        check("stream_count", 129'(pop_cyc.size() - n0), 129'(16));
        check("stream_contig", 129'(pop_cyc[pop_cyc.size()-1] - pop_cyc[n0]), 129'(15));

        // Backpressure for three cycles mid-stream.
        n0 = pop_cyc.size();
        fork
            begin
                for (int k = 0; k < 10; k++) send(rand_word(), k[1], tr);
                in_valid = 1'b0;
            end
            begin
                repeat (4) begin
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b0;
                repeat (3) @(negedge clk);
                check("bp_in_ready", 129'(in_ready),  129'(0));
                check("bp_busy",     129'(busy),      129'(1));
                check("bp_valid",    129'(out_valid), 129'(1));
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", 129'(pop_cyc.size() - n0), 129'(10));

        // Mid-flight reset with both stages full.
        out_ready = 1'b0;
        send(rand_word(), 1'b0, tr);
        send(rand_word(), 1'b1, tr);
        in_valid = 1'b0;
        @(negedge clk);
        check("full_in_ready", 129'(in_ready),  129'(0));
        check("full_valid",    129'(out_valid), 129'(1));
        @(posedge clk);
        #1;
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = rand_word();
        sb.delete();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n0 = pop_cyc.size();
        repeat (6) @(negedge clk);
        check("mid_rst_valid", 129'(out_valid), 129'(0));
        check("mid_rst_busy",  129'(busy),      129'(0));
        check("mid_rst_pops",  129'(pop_cyc.size() - n0), 129'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
